// File: rtl/up_arbiter_if.sv
// Bundle of requester-side and slave-side uP signals around up_arbiter.
// The master modport is the arbiter's view; the slave modport is its environment's.
interface up_arbiter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int NUM_PORTS     = 2
);
  logic [NUM_PORTS-1:0]                 s_up_rreq;
  logic [NUM_PORTS-1:0]                 s_up_rack;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]   s_up_raddr;
  logic [BUS_WIDTH*8-1:0]               s_up_rdata;
  logic [NUM_PORTS-1:0]                 s_up_wreq;
  logic [NUM_PORTS-1:0]                 s_up_wack;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]   s_up_waddr;
  logic [NUM_PORTS*BUS_WIDTH*8-1:0]     s_up_wdata;
  logic                                 m_up_rreq;
  logic [ADDRESS_WIDTH-1:0]             m_up_raddr;
  logic                                 m_up_rack;
  logic [BUS_WIDTH*8-1:0]               m_up_rdata;
  logic                                 m_up_wreq;
  logic [ADDRESS_WIDTH-1:0]             m_up_waddr;
  logic [BUS_WIDTH*8-1:0]               m_up_wdata;
  logic                                 m_up_wack;
  logic [NUM_PORTS-1:0]                 grant;
  logic                                 timeout;

  modport master (
    input  s_up_rreq, s_up_raddr, s_up_wreq, s_up_waddr, s_up_wdata,
    input  m_up_rack, m_up_rdata, m_up_wack,
    output s_up_rack, s_up_rdata, s_up_wack,
    output m_up_rreq, m_up_raddr, m_up_wreq, m_up_waddr, m_up_wdata,
    output grant, timeout
  );

  modport slave (
    output s_up_rreq, s_up_raddr, s_up_wreq, s_up_waddr, s_up_wdata,
    output m_up_rack, m_up_rdata, m_up_wack,
    input  s_up_rack, s_up_rdata, s_up_wack,
    input  m_up_rreq, m_up_raddr, m_up_wreq, m_up_waddr, m_up_wdata,
    input  grant, timeout
  );
endinterface

// File: rtl/up_arbiter.sv
// Round-robin arbiter sharing one uP register slave between NUM_PORTS requesters, 3-cycle minimum occupancy.
// Define UP_ARBITER_TIMEOUT_EN to add a watchdog that retires unacknowledged slave transactions.
module up_arbiter #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 4,
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  up_arbiter_if.master bus
);
  localparam int DW = BUS_WIDTH * 8;
  localparam int IW = $clog2(NUM_PORTS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("up_arbiter: unsupported parameter set");
  end

  logic [1:0]               state_q, state_d;
  logic [NUM_PORTS-1:0]     grant_q, grant_d;
  logic [IW-1:0]            win_q, win_d;
  logic [IW-1:0]            last_q, last_d;
  logic                     is_wr_q, is_wr_d;
  logic                     m_rreq_q, m_rreq_d;
  logic                     m_wreq_q, m_wreq_d;
  logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [DW-1:0]            wdata_q, wdata_d;
  logic [DW-1:0]            rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]     rack_q, rack_d;
  logic [NUM_PORTS-1:0]     wack_q, wack_d;

  logic [NUM_PORTS-1:0]     cand;
  logic                     cand_found;
  logic [IW-1:0]            cand_idx;
  logic                     slv_ack;
  logic                     expired;

  assign cand    = bus.s_up_rreq | bus.s_up_wreq;
  // Only the ack of the latched direction can end a transaction.
  assign slv_ack = is_wr_q ? bus.m_up_wack : bus.m_up_rack;

  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!cand_found && cand[(int'(last_q) + k) % NUM_PORTS]) begin
        cand_found = 1'b1;
        cand_idx   = IW'((int'(last_q) + k) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    win_d    = win_q;
    last_d   = last_q;
    is_wr_d  = is_wr_q;
    m_rreq_d = m_rreq_q;
    m_wreq_d = m_wreq_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rack_d   = '0;
    wack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cand_found) begin
          grant_d = NUM_PORTS'(1) << cand_idx;
          win_d   = cand_idx;
          is_wr_d = bus.s_up_wreq[cand_idx];
          if (bus.s_up_wreq[cand_idx]) begin
            m_wreq_d = 1'b1;
            waddr_d  = bus.s_up_waddr[int'(cand_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            wdata_d  = bus.s_up_wdata[int'(cand_idx)*DW +: DW];
          end else begin
            m_rreq_d = 1'b1;
            raddr_d  = bus.s_up_raddr[int'(cand_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          end
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (slv_ack || expired) begin
          m_rreq_d = 1'b0;
          m_wreq_d = 1'b0;
          if (is_wr_q) begin
            wack_d[win_q] = 1'b1;
          end else begin
            rack_d[win_q] = 1'b1;
            rdata_d       = slv_ack ? bus.m_up_rdata : '0;
          end
          last_d  = win_q;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      win_q    <= '0;
      last_q   <= IW'(NUM_PORTS - 1);
      is_wr_q  <= 1'b0;
      m_rreq_q <= 1'b0;
      m_wreq_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rack_q   <= '0;
      wack_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      win_q    <= win_d;
      last_q   <= last_d;
      is_wr_q  <= is_wr_d;
      m_rreq_q <= m_rreq_d;
      m_wreq_q <= m_wreq_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rack_q   <= rack_d;
      wack_q   <= wack_d;
    end
  end

`ifdef UP_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // cnt_q holds the number of completed BUSY cycles, so the limit is hit on the last one.
  assign expired   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d     = (state_q == ST_BUSY) ? cnt_q + CW'(1) : '0;
  assign timeout_d = (state_q == ST_BUSY) && expired && !slv_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expired     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant      = grant_q;
  assign bus.s_up_rack  = rack_q;
  assign bus.s_up_wack  = wack_q;
  assign bus.s_up_rdata = rdata_q;
  assign bus.m_up_rreq  = m_rreq_q;
  assign bus.m_up_raddr = raddr_q;
  assign bus.m_up_wreq  = m_wreq_q;
  assign bus.m_up_waddr = waddr_q;
  assign bus.m_up_wdata = wdata_q;
endmodule

// File: tb/tb_up_arbiter.sv
// Bench for up_arbiter: directed scenarios and random traffic against a transaction-level round-robin model.
// The watchdog scenario follows UP_ARBITER_TIMEOUT_EN.
module tb_up_arbiter;
  localparam int AW = 16;
  localparam int BW = 4;
  localparam int DW = BW * 8;
  localparam int NP = 3;
  localparam int TO = 8;
`ifdef UP_ARBITER_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int RST_AT = 3;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int RST_AT = 20;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  up_arbiter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .NUM_PORTS(NP)) bus ();

  up_arbiter #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requester state: what each port is currently holding on its bus.
  logic          r_req [NP];
  logic          w_req [NP];
  logic [AW-1:0] r_addr[NP];
  logic [AW-1:0] w_addr[NP];
  logic [DW-1:0] w_dat [NP];

  // Transaction model: 0 = arbiter free, 1 = transaction outstanding, 2 = ack cycle.
  int            m_phase, last_w, win, lat_wait, cur_lat, bcnt, hi, n_done, n_to, first_win;
  bit            win_wr, ack_prev, first_after_rst;
  logic [DW-1:0] exp_rd;

  int            gen_pct, lat_lo, lat_hi;
  logic [NP-1:0] gen_mask;
  bit            mute, spur, fix_en;
  logic [DW-1:0] fix_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    oh    = '0;
    oh[p] = 1'b1;
  endfunction

  function automatic int rr_pick(input int last);
    rr_pick = -1;
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (last + k) % NP;
      if (rr_pick < 0 && (r_req[p] || w_req[p])) rr_pick = p;
    end
  endfunction

  function automatic bit any_req();
    any_req = 1'b0;
    for (int p = 0; p < NP; p++) if (r_req[p] || w_req[p]) any_req = 1'b1;
  endfunction

  task automatic drive_bus();
    for (int p = 0; p < NP; p++) begin
      bus.s_up_rreq[p]           = r_req[p];
      bus.s_up_wreq[p]           = w_req[p];
      bus.s_up_raddr[p*AW +: AW] = r_addr[p];
      bus.s_up_waddr[p*AW +: AW] = w_addr[p];
      bus.s_up_wdata[p*DW +: DW] = w_dat[p];
    end
  endtask

  task automatic issue(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (wr) begin
      w_req[p] = 1'b1; w_addr[p] = a; w_dat[p] = d;
    end else begin
      r_req[p] = 1'b1; r_addr[p] = a;
    end
    drive_bus();
  endtask

  task automatic cycle();
    int            acked;
    logic [NP-1:0] exp_r, exp_w;
    acked = -1;
    @(posedge clk); #1;
    if (m_phase == 1 && (ack_prev || (TO_EN && bcnt + 1 == TO))) begin
      bit to_fire;
      to_fire = !ack_prev;
      exp_r   = win_wr ? '0 : oh(win);
      exp_w   = win_wr ? oh(win) : '0;
      chk("s_rack", 64'(bus.s_up_rack), 64'(exp_r));
      chk("s_wack", 64'(bus.s_up_wack), 64'(exp_w));
      chk("mreq_drop", 64'({bus.m_up_rreq, bus.m_up_wreq}), 64'd0);
      chk("grant_hold", 64'(bus.grant), 64'(oh(win)));
      chk("timeout", 64'(bus.timeout), 64'(to_fire));
      if (!win_wr) chk("rdata", 64'(bus.s_up_rdata), to_fire ? 64'd0 : 64'(exp_rd));
      if (!to_fire) chk("busy_len", 64'(hi), 64'(cur_lat + 1));
      if (to_fire) n_to++;
      n_done++;
      acked   = win;
      m_phase = 2;
    end else if (m_phase == 2) begin
      chk("ack_clear", 64'({bus.s_up_rack, bus.s_up_wack, bus.grant,
                            bus.m_up_rreq, bus.m_up_wreq, bus.timeout}), 64'd0);
      m_phase = 0;
    end else if (m_phase == 1) begin
      bcnt++;
      hi++;
      chk("busy_req", 64'({bus.m_up_rreq, bus.m_up_wreq}), win_wr ? 64'd1 : 64'd2);
      chk("busy_grant", 64'(bus.grant), 64'(oh(win)));
      chk("busy_quiet", 64'({bus.s_up_rack, bus.s_up_wack, bus.timeout}), 64'd0);
    end else begin
      int p;
      p = rr_pick(last_w);
      if (p < 0) begin
        chk("idle", 64'({bus.grant, bus.m_up_rreq, bus.m_up_wreq}), 64'd0);
      end else begin
        win    = p;
        win_wr = w_req[p];
        last_w = p;
        if (first_after_rst) begin
          first_win       = p;
          first_after_rst = 1'b0;
        end
        chk("grant", 64'(bus.grant), 64'(oh(p)));
        chk("dir", 64'({bus.m_up_rreq, bus.m_up_wreq}), win_wr ? 64'd1 : 64'd2);
        if (win_wr) begin
          chk("waddr", 64'(bus.m_up_waddr), 64'(w_addr[p]));
          chk("wdata", 64'(bus.m_up_wdata), 64'(w_dat[p]));
        end else begin
          chk("raddr", 64'(bus.m_up_raddr), 64'(r_addr[p]));
        end
        m_phase  = 1;
        bcnt     = 0;
        hi       = 1;
        cur_lat  = int'($urandom_range(lat_hi, lat_lo));
        lat_wait = cur_lat;
      end
    end

    // Slave responder.
    ack_prev         = 1'b0;
    bus.m_up_rack    = 1'b0;
    bus.m_up_wack    = 1'b0;
    bus.m_up_rdata   = DW'($urandom);
    if (m_phase == 1 && !mute) begin
      if (lat_wait == 0) begin
        exp_rd         = fix_en ? fix_rd : DW'($urandom);
        bus.m_up_rdata = exp_rd;
        if (win_wr) bus.m_up_wack = 1'b1;
        else        bus.m_up_rack = 1'b1;
        ack_prev = 1'b1;
      end else begin
        lat_wait--;
        if (spur && $urandom_range(1, 0) == 1) begin
          if (win_wr) bus.m_up_rack = 1'b1;
          else        bus.m_up_wack = 1'b1;
        end
      end
    end

    // Requesters drop the acked request, then idle ports may start a new one.
    if (acked >= 0) begin
      if (win_wr) w_req[acked] = 1'b0;
      else        r_req[acked] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      if (p != acked && gen_mask[p] && !r_req[p] && !w_req[p] &&
          int'($urandom_range(99, 0)) < gen_pct) begin
        if ($urandom_range(1, 0) == 1) issue(p, 1'b1, AW'($urandom), DW'($urandom));
        else                           issue(p, 1'b0, AW'($urandom), '0);
      end
    end
    drive_bus();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_phase != 0 || any_req()) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain", 64'(m_phase != 0 || any_req()), 64'd0);
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    #1;
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_acks", 64'({bus.s_up_rack, bus.s_up_wack}), 64'd0);
    chk("rst_mreq", 64'({bus.m_up_rreq, bus.m_up_wreq, bus.timeout}), 64'd0);
    chk("rst_addr", 64'({bus.m_up_raddr, bus.m_up_waddr}), 64'd0);
    chk("rst_data", {bus.m_up_wdata, bus.s_up_rdata}, 64'd0);
    m_phase         = 0;
    last_w          = NP - 1;
    ack_prev        = 1'b0;
    mute            = 1'b0;
    first_after_rst = 1'b1;
    bus.m_up_rack   = 1'b0;
    bus.m_up_wack   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    for (int p = 0; p < NP; p++) begin
      r_req[p] = 1'b0; w_req[p] = 1'b0;
      r_addr[p] = '0; w_addr[p] = '0; w_dat[p] = '0;
    end
    m_phase = 0; last_w = NP - 1; win = 0; lat_wait = 0; cur_lat = 0; bcnt = 0; hi = 0;
    n_done = 0; n_to = 0; first_win = -1; win_wr = 1'b0; ack_prev = 1'b0; exp_rd = '0;
    gen_pct = 0; gen_mask = '0; lat_lo = 0; lat_hi = 0; mute = 1'b0; spur = 1'b0;
    fix_en = 1'b0; fix_rd = '0; first_after_rst = 1'b0;
    bus.m_up_rack = 1'b0; bus.m_up_wack = 1'b0; bus.m_up_rdata = '0;
    drive_bus();
    #3;
    reset_seq();

    // Single read on port 0, slave answers two cycles late.
    lat_lo = 2; lat_hi = 2; fix_en = 1'b1; fix_rd = 32'hA5A5_A5A5;
    issue(0, 1'b0, 16'h0010, '0);
    drain(40);
    fix_en = 1'b0;

    // Simultaneous writes from ports 0 and 1 straight after reset, immediate slave ack.
    reset_seq();
    lat_lo = 0; lat_hi = 0;
    issue(0, 1'b1, 16'h1000, 32'h1111_0000);
    issue(1, 1'b1, 16'h2000, 32'h2222_0000);
    drain(40);

    // Ports 0 and 1 requesting continuously: strict alternation.
    gen_mask = 3'b011; gen_pct = 100; n_done = 0;
    for (int i = 0; i < 200 && n_done < 6; i++) cycle();
    chk("rotation_count", 64'(n_done >= 6), 64'd1);
    gen_pct = 0;
    drain(60);

    // Read and write raised together on port 1: write goes first.
    issue(1, 1'b1, 16'h3000, 32'hDEAD_BEEF);
    issue(1, 1'b0, 16'h3004, '0);
    drain(40);

    // Random traffic on all ports with varying latency and stray opposite-direction acks.
    gen_mask = '1; gen_pct = 30; lat_lo = 0; lat_hi = 4; spur = 1'b1;
    for (int i = 0; i < 400; i++) cycle();
    gen_pct = 0;
    drain(100);
    spur = 1'b0;

`ifdef UP_ARBITER_TIMEOUT_EN
    // Slave never answers: watchdog retires the read, then the waiting port is served.
    mute = 1'b1; n_done = 0; n_to = 0;
    issue(1, 1'b0, 16'h4000, '0);
    cycle();
    issue(2, 1'b0, 16'h4004, '0);
    n = 0;
    while (n_done == 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("timeout_seen", 64'(n_to), 64'd1);
    mute = 1'b0;
    drain(40);
`endif

    // Reset while a transaction is stuck in BUSY; afterwards port 0 must win first.
    mute = 1'b1; lat_lo = 0; lat_hi = 2;
    issue(0, 1'b0, 16'h5000, '0);
    issue(1, 1'b0, 16'h5004, '0);
    issue(2, 1'b0, 16'h5008, '0);
    n = 0;
    while (!(m_phase == 1 && bcnt >= RST_AT) && n < 60) begin
      cycle();
      n++;
    end
    chk("reached_busy", 64'(m_phase == 1 && bcnt >= RST_AT), 64'd1);
    reset_seq();
    drain(80);
    chk("post_rst_winner", 64'(first_win), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/up_arbiter.md
# up_arbiter

Round-robin arbiter that shares one uP register slave between NUM_PORTS uP requesters, for example an APB3 bridge and a local sequencer. It grants one transaction at a time, forwards the winning request, address and write data to the slave, and returns the slave's ack and read data to the granted requester only. Slave-side outputs are registered. An optional watchdog retires transactions that the slave never acknowledges.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, uP address width.
- BUS_WIDTH, 4, data width in bytes; data buses are BUS_WIDTH*8 bits.
- NUM_PORTS, 2, number of requesters; legal range 2–8.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with UP_ARBITER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_up_rreq  in  NUM_PORTS  per-port read request.
- s_up_rack  out  NUM_PORTS  per-port read ack, one-cycle pulse.
- s_up_raddr  in  NUM_PORTS*ADDRESS_WIDTH  per-port read address; port i occupies slice i.
- s_up_rdata  out  BUS_WIDTH*8  read data, shared by all ports; valid only in a port's rack cycle.
- s_up_wreq  in  NUM_PORTS  per-port write request.
- s_up_wack  out  NUM_PORTS  per-port write ack, one-cycle pulse.
- s_up_waddr  in  NUM_PORTS*ADDRESS_WIDTH  per-port write address.
- s_up_wdata  in  NUM_PORTS*BUS_WIDTH*8  per-port write data.
- m_up_rreq / m_up_raddr  out  1 / ADDRESS_WIDTH  slave read request and address.
- m_up_rack / m_up_rdata  in  1 / BUS_WIDTH*8  slave read ack and data.
- m_up_wreq / m_up_waddr / m_up_wdata  out  1 / ADDRESS_WIDTH / BUS_WIDTH*8  slave write request, address and data.
- m_up_wack  in  1  slave write ack.
- grant  out  NUM_PORTS  one-hot owner of the current transaction; all zero when idle.
- timeout  out  1  one-cycle pulse when the watchdog fires; tied to 0 when the watchdog is compiled out.

## Operation
- Requester rules:
  - A requester holds its req level-high, with stable address and data, until it sees its ack.
  - It drops req in the cycle after the ack.
  - It never has a read and a write pending at the same time. If both are seen on one port, the write is served first.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - Candidates are all ports with rreq or wreq set.
  - Pick the first candidate searching upward (with wrap) from last_winner+1. last_winner resets to NUM_PORTS-1, so port 0 has first priority after reset.
  - Register grant, the latched read/write direction, the address, the write data and the matching m_up_*req. Go to BUSY.
- BUSY:
  - m_up_*req stays high until the matching m_up_*ack is sampled.
  - On that edge: clear m_up_*req, pulse the granted port's s_up_*ack, register m_up_rdata into s_up_rdata (reads only), update last_winner, go to ACK.
- ACK: clear the ack pulse and grant; go to IDLE. IDLE may grant a new winner in the very next cycle.
- The acked port has dropped its req by the time IDLE re-evaluates, so a stale request is never re-granted.
- The ack input of the non-latched direction is ignored in every state.
- Requests arriving during BUSY or ACK wait; no request is ever lost or preempted.

## Timing
- Reset values: all acks, m_up_rreq, m_up_wreq, grant and timeout are 0. All addresses and data are 0. State is IDLE.
- Cycle numbering: request seen at edge n; slave ack seen at edge k.
  - Edge n: the slave request and grant go high.
  - Edge k: the slave request drops and the requester ack rises.
  - Edge k+1: the requester ack drops.
- Minimum occupancy, with the slave acking in the first BUSY cycle, is 3 cycles per transaction.
- Back-to-back throughput with all ports busy is one transaction per 3 cycles, in strict rotation.
- Reset asserted mid-transaction forces every output to its reset value immediately (asynchronous). Any outstanding slave transaction is abandoned.

## Configuration
- UP_ARBITER_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no slave ack, the arbiter:
    - clears the slave request;
    - acks the granted port with s_up_rdata = 0 (reads);
    - pulses timeout;
    - goes to ACK.
- UP_ARBITER_TIMEOUT_EN not defined: no counter; BUSY waits indefinitely; timeout is constant 0.

## Test plan
- Single read, port 0, raddr=0x0010, slave acks 2 cycles later with 0xA5A5A5A5 -> m_up_rreq high for 3 cycles; s_up_rack[0] pulses once with s_up_rdata=0xA5A5A5A5; grant=01 during the transaction.
- Ports 0 and 1 write simultaneously after reset, slave acks immediately -> port 0 is served first, then port 1; m_up_waddr/wdata match each port in turn; each transaction takes 3 cycles.
- Both ports request continuously for 6 transactions -> grant sequence 01,10,01,10,01,10; no port is acked twice in a row.
- Port 1 asserts rreq and wreq together -> the write completes first (wack[1]), then the read; no overlap on the slave bus.
- Slave never acks, TIMEOUT_CYCLES=8, macro defined -> timeout and rack pulse on the 8th BUSY cycle with rdata=0; the next requester is granted afterwards. Without the macro, m_up_rreq stays high.
- rst asserted low while in BUSY -> all outputs are 0 immediately. After release, port 0 wins the first grant.
